// File: rtl/xmit_cu_pkg.sv
// xmit_cu_pkg: state encoding and byte width shared by the UART/FIR transmit and receive control units.
package xmit_cu_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START_HI = 3'd1,
        WAIT_HI  = 3'd2,
        START_LO = 3'd3,
        WAIT_LO  = 3'd4
    } tx_state_t;
endpackage

// File: rtl/xmit_fifo.sv
// xmit_fifo: sample buffer with push/pop/full/empty/count; a push into a full FIFO is accepted only alongside a pop.
module xmit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_count;
    logic              w_pop;
    logic              w_push;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_full  = r_count == (AW + 1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end
endmodule

// File: rtl/xmit_cu.sv
// xmit_cu: buffers FIR samples and sends each one to the UART transmitter as two bytes, MSB first,
// using the TxD_start / TxD_busy handshake.
module xmit_cu
    import xmit_cu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FIR_done,
    input  logic [DATA_W-1:0] FIR_out,
    input  logic              TxD_busy,
    output logic              TxD_start,
    output logic [7:0]        TxD_data,
    output logic              sample_drop,
    output logic              fifo_empty,
    output logic              tx_idle
);
    if (DATA_W != 2 * BYTE_W) begin : g_bad_width
        $error("xmit_cu: DATA_W must be 16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("xmit_cu: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    tx_state_t                   r_state;
    tx_state_t                   w_next;
    logic [DATA_W-1:0]           r_hold;
    logic [BYTE_W-1:0]           r_data;
    logic                        r_guard;
    logic                        r_drop;
    logic [DATA_W-1:0]           w_head;
    logic [DATA_W-1:0]           w_src;
    logic                        w_pop;
    logic                        w_full;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    xmit_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (FIR_done),
        .i_pop   (w_pop),
        .i_data  (FIR_out),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (fifo_empty),
        .o_count (w_count)
    );
    assign w_pop       = (r_state == IDLE) && !fifo_empty;
    assign TxD_start   = (r_state == START_HI) || (r_state == START_LO);
    assign TxD_data    = r_data;
    assign sample_drop = r_drop;
    assign tx_idle     = (r_state == IDLE) && (w_count == '0);
    // Hold rotates by a byte when the LSB is sent, so the byte to send next is always the top one.
    assign w_src = (r_state == IDLE) ? w_head : {r_hold[BYTE_W-1:0], r_hold[DATA_W-1 -: BYTE_W]};
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = fifo_empty ? IDLE : START_HI;
            START_HI: w_next = WAIT_HI;
            WAIT_HI:  w_next = (r_guard && !TxD_busy) ? START_LO : WAIT_HI;
            START_LO: w_next = WAIT_LO;
            WAIT_LO:  w_next = (r_guard && !TxD_busy) ? IDLE : WAIT_LO;
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_data  <= '0;
            r_guard <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_guard <= (r_state == WAIT_HI) || (r_state == WAIT_LO);
            r_drop  <= FIR_done && w_full && !w_pop;
            if (w_next == START_HI || w_next == START_LO) begin
                r_hold <= w_src;
                r_data <= w_src[DATA_W-1 -: BYTE_W];
            end
        end
    end
endmodule
